mem_access_unit: RTL and testbench

- Memory-access (MEM) stage; sits directly upstream of the MEM/WB pipeline latch.
- Converts the EX/MEM load/store control and ALU address into a req/ack data-memory transaction with byte enables.
- Byte/half/word-extracts and sign- or zero-extends load data; the result feeds the latch's load-data input.
- Holds the pipeline with a stall output while a transaction is outstanding.

---
 rtl/mem_access_unit_if.sv | 15 +
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// mem_access_unit_if: data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// mem_access_unit: MEM stage turning EX/MEM load/store control into a req/ack transaction, rev 1.0.
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inValid,
  input  logic                     inMemRead,
  input  logic                     inMemWrite,
  input  logic [2:0]               inLsType,
  input  logic [31:0]              inAluResult,
  input  logic [31:0]              inWriteData,
  mem_access_unit_if.master        dmem,
  output logic [31:0]              outLoadWordDividerMEM,
  output logic                     outStall,
  output logic                     outBusError,
  output logic                     outAddrError
);
  localparam logic [TO_CNT_W-1:0] CNT_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic                sgn_q;
  logic                is_byte, is_half, is_word, mem_op, trap, start;
  logic [1:0]          off;
  logic [3:0]          be;
  logic [31:0]         wdata;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_ext;

  // Reserved type encodings fall through to word accesses.
  assign is_byte = (inLsType[1:0] == 2'b00);
  assign is_half = (inLsType[1:0] == 2'b01);
  assign is_word = inLsType[1];
  assign mem_op  = inValid & (inMemRead | inMemWrite);

`ifdef MISALIGN_TRAP_EN
  logic addr_err;
  assign trap         = mem_op & ((is_half & inAluResult[0]) | (is_word & |inAluResult[1:0]));
  assign outAddrError = addr_err;
`else
  assign trap         = 1'b0;
  assign outAddrError = 1'b0;
`endif

  assign start    = mem_op & ~trap;
  assign outStall = ((state == S_IDLE) & start) | (state == S_WAIT);

  always_comb begin
    off   = 2'b00;
    be    = 4'hF;
    wdata = '0;
    if (is_byte)
      off = inAluResult[1:0];
    else if (is_half)
      off = {inAluResult[1], 1'b0};
    if (inMemWrite) begin
      if (is_byte) begin
        be    = 4'b0001 << off;
        wdata = {4{inWriteData[7:0]}};
      end else if (is_half) begin
        be    = inAluResult[1] ? 4'b1100 : 4'b0011;
        wdata = {2{inWriteData[15:0]}};
      end else begin
        wdata = inWriteData;
      end
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem.rdata[7:0];
      2'd1:    ld_byte = dmem.rdata[15:8];
      2'd2:    ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    ld_ext  = dmem.rdata;
    if (size_q == 2'b00)
      ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
    else if (size_q == 2'b01)
      ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      to_cnt                <= '0;
      dmem.req              <= 1'b0;
      dmem.we               <= 1'b0;
      dmem.be               <= '0;
      dmem.addr             <= '0;
      dmem.wdata            <= '0;
      outLoadWordDividerMEM <= '0;
      outBusError           <= 1'b0;
      size_q                <= '0;
      off_q                 <= '0;
      sgn_q                 <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      addr_err              <= 1'b0;
`endif
    end else begin
      outBusError <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      addr_err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            dmem.req   <= 1'b1;
            dmem.we    <= inMemWrite;
            dmem.addr  <= {inAluResult[31:2], 2'b00};
            dmem.be    <= be;
            dmem.wdata <= wdata;
            size_q     <= inLsType[1:0];
            off_q      <= off;
            sgn_q      <= ~inLsType[2];
            to_cnt     <= '0;
            state      <= S_WAIT;
          end
`ifdef MISALIGN_TRAP_EN
          else if (trap) begin
            addr_err              <= 1'b1;
            outLoadWordDividerMEM <= '0;
          end
`endif
        end
        S_WAIT: begin
          // Ack is checked first so a response on the final cycle beats the timeout.
          if (dmem.ack) begin
            outLoadWordDividerMEM <= dmem.we ? 32'd0 : ld_ext;
            dmem.req              <= 1'b0;
            dmem.we               <= 1'b0;
            state                 <= S_DONE;
          end else if (to_cnt == CNT_LAST) begin
            outBusError           <= 1'b1;
            outLoadWordDividerMEM <= '0;
            dmem.req              <= 1'b0;
            dmem.we               <= 1'b0;
            state                 <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit: random + directed scoreboard bench for the MEM-stage access unit.
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, inMemRead, inMemWrite;
  logic [2:0]  inLsType;
  logic [31:0] inAluResult, inWriteData;
  logic [31:0] outLoadWordDividerMEM;
  logic        outStall, outBusError, outAddrError;

  mem_access_unit_if dmem ();

  mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .TO_CNT_W(5)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .inValid               (inValid),
    .inMemRead             (inMemRead),
    .inMemWrite            (inMemWrite),
    .inLsType              (inLsType),
    .inAluResult           (inAluResult),
    .inWriteData           (inWriteData),
    .dmem                  (dmem),
    .outLoadWordDividerMEM (outLoadWordDividerMEM),
    .outStall              (outStall),
    .outBusError           (outBusError),
    .outAddrError          (outAddrError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] data;
    logic        berr;
    int          stall_len;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   prev_req = 1'b0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte lanes and extension derived from access size and byte offset.
  function automatic exp_t model(input logic wr, input logic [2:0] t, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdt, input int delay);
    exp_t        e;
    int          size, off;
    logic [31:0] eff, v, mask;
    size   = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    eff    = a & ~(32'(size) - 32'd1);
    off    = int'(eff[1:0]);
    e.addr = eff & 32'hFFFF_FFFC;
    e.we   = wr;
    e.be   = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
    for (int b = 0; b < 4; b++) e.wdata[8*b +: 8] = wd[8*(b % size) +: 8];
    e.berr      = (delay == 0) || (delay > TIMEOUT);
    e.stall_len = 1 + (e.berr ? TIMEOUT : delay);
    if (wr || e.berr) begin
      e.data = 32'd0;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v    = (rdt >> (8 * off)) & mask;
      if (!t[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.data = v;
    end
    return e;
  endfunction

  // delay: WAIT cycle that carries ack (1..TIMEOUT), 0 for no ack at all.
  task automatic access(input logic v, input logic rd, input logic wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt,
                        input int delay);
    inValid = v; inMemRead = rd; inMemWrite = wr; inLsType = t;
    inAluResult = a; inWriteData = wd;
    if (!(v && (rd || wr))) begin
      @(posedge clk); #1;
      return;
    end
    sb.push_back(model(wr, t, a, wd, rdt, delay));
    @(posedge clk); #1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      dmem.ack   = (k == delay);
      dmem.rdata = (k == delay) ? rdt : $urandom;
      @(posedge clk); #1;
      if (k == delay) break;
    end
    dmem.ack = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: request fields on req rise, result/stall/bus-error on req fall.
  always @(negedge clk) begin
    if (mon_en) begin
      if (outStall) stall_cnt++;
      if (dmem.req && !prev_req) begin
        if (sb.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          chk("req_addr", dmem.addr, sb[0].addr);
          chk("req_we", {31'd0, dmem.we}, {31'd0, sb[0].we});
          chk("req_be", {28'd0, dmem.be}, {28'd0, sb[0].be});
          if (sb[0].we) chk("req_wdata", dmem.wdata, sb[0].wdata);
        end
      end
      if (!dmem.req && prev_req) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("load_data", outLoadWordDividerMEM, e.data);
          chk("bus_error", {31'd0, outBusError}, {31'd0, e.berr});
          chk("stall_len", 32'(stall_cnt), 32'(e.stall_len));
          chk("done_stall", {31'd0, outStall}, 32'd0);
        end
        stall_cnt = 0;
      end else begin
        chk("berr_quiet", {31'd0, outBusError}, 32'd0);
      end
      if (!(inValid && (inMemRead || inMemWrite))) chk("nonmem_stall", {31'd0, outStall}, 32'd0);
    end else begin
      stall_cnt = 0;
    end
    prev_req = dmem.req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0] load_types [8];

  initial begin
    load_types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst_n = 1'b0;
    inValid = 0; inMemRead = 0; inMemWrite = 0; inLsType = 0;
    inAluResult = 0; inWriteData = 0; dmem.ack = 0; dmem.rdata = 0;
    #3;
    chk("rst_req", {31'd0, dmem.req}, 32'd0);
    chk("rst_we", {31'd0, dmem.we}, 32'd0);
    chk("rst_be", {28'd0, dmem.be}, 32'd0);
    chk("rst_addr", dmem.addr, 32'd0);
    chk("rst_wdata", dmem.wdata, 32'd0);
    chk("rst_data", outLoadWordDividerMEM, 32'd0);
    chk("rst_stall", {31'd0, outStall}, 32'd0);
    chk("rst_berr", {31'd0, outBusError}, 32'd0);
    chk("rst_aerr", {31'd0, outAddrError}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    access(1, 1, 0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 2);
    access(1, 1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 1);
    access(1, 1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 3);
    access(1, 1, 0, 3'b101, 32'h202, 32'h0, 32'h80FF_0000, 1);
    access(1, 0, 1, 3'b001, 32'h012, 32'h0000ABCD, 32'h0, 1);
    access(1, 0, 0, 3'b010, 32'h40, 32'h0, 32'h0, 1);
    access(1, 1, 0, 3'b010, 32'h500, 32'h0, 32'h1, 0);
    access(1, 1, 0, 3'b001, 32'h502, 32'h0, 32'h8001_7FFF, TIMEOUT);
    access(1, 1, 1, 3'b000, 32'h601, 32'h5A, 32'hFFFF_FFFF, 1);

    for (int n = 0; n < 150; n++) begin
      logic       v, rd, wr;
      logic [2:0] t;
      logic [31:0] a;
      int         kind, r, delay;
      kind = $urandom_range(0, 9);
      v    = ($urandom_range(0, 7) != 0);
      rd   = (kind >= 2 && kind < 6) || kind == 9;
      wr   = (kind >= 6);
      t    = wr ? 3'($urandom_range(0, 2)) : load_types[$urandom_range(0, 7)];
      a    = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (t[1:0] == 2'b01) a[0] = 1'b0;
      else if (t[1] == 1'b1) a[1:0] = 2'b00;
`endif
      r     = $urandom_range(0, 9);
      delay = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 4);
      access(v, rd, wr, t, a, $urandom, $urandom, delay);
    end

    // Reset while waiting for ack, then a stray ack in IDLE.
    mon_en = 1'b0;
    inValid = 1; inMemRead = 1; inMemWrite = 0; inLsType = 3'b010; inAluResult = 32'h300;
    @(posedge clk); #1;
    chk("midrst_req_before", {31'd0, dmem.req}, 32'd1);
    #1;
    rst_n = 1'b0; inValid = 0; inMemRead = 0;
    #1;
    chk("midrst_req", {31'd0, dmem.req}, 32'd0);
    chk("midrst_stall", {31'd0, outStall}, 32'd0);
    chk("midrst_be", {28'd0, dmem.be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem.ack = 1'b1; dmem.rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_req", {31'd0, dmem.req}, 32'd0);
    chk("stray_ack_data", outLoadWordDividerMEM, 32'd0);
    chk("stray_ack_stall", {31'd0, outStall}, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    access(1, 1, 0, 3'b010, 32'h308, 32'h0, 32'hCAFE_F00D, 1);

`ifdef MISALIGN_TRAP_EN
    mon_en = 1'b0;
    inValid = 1; inMemRead = 1; inMemWrite = 0; inLsType = 3'b010; inAluResult = 32'h101;
    @(negedge clk);
    chk("trap_req", {31'd0, dmem.req}, 32'd0);
    chk("trap_stall", {31'd0, outStall}, 32'd0);
    @(posedge clk); #1;
    inValid = 0; inMemRead = 0;
    chk("trap_aerr", {31'd0, outAddrError}, 32'd1);
    chk("trap_data", outLoadWordDividerMEM, 32'd0);
    @(posedge clk); #1;
    chk("trap_aerr_pulse", {31'd0, outAddrError}, 32'd0);
    mon_en = 1'b1;
`else
    access(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h0BAD_F00D, 2);
    chk("aerr_tied", {31'd0, outAddrError}, 32'd0);
`endif

    inValid = 0; inMemRead = 0; inMemWrite = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
